// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation, STEPS = E/2 cycles.
// start is taken only in IDLE; abort cancels a CALC without touching product.
module booth_r4_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic           tc,
  input  logic           abort,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int E     = (N % 2 == 1) ? N + 1 : N + 2;
  localparam int STEPS = E / 2;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int PW    = 2 * N;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [E-1:0]  a_q;
  logic [E-1:0]  b_q;
  logic          hist;
  logic [E+1:0]  acc;
  logic [CW-1:0] cnt;

  logic [E+1:0]  a_x1;
  logic [E+1:0]  a_x2;
  logic [E+1:0]  mult;
  logic [E+1:0]  sum;
  logic [E+1:0]  acc_nxt;
  logic [E-1:0]  b_nxt;
  logic [E-1:0]  a_ld;
  logic [E-1:0]  b_ld;
  logic [PW-1:0] res;
  logic          last;

  // Two guard bits on the accumulator keep +/-2A from overflowing.
  assign a_x1 = {{2{a_q[E-1]}}, a_q};
  assign a_x2 = {a_q[E-1], a_q, 1'b0};

  always_comb begin
    mult = '0;
    case ({b_q[1:0], hist})
      3'b001, 3'b010: mult = a_x1;
      3'b011:         mult = a_x2;
      3'b100:         mult = -a_x2;
      3'b101, 3'b110: mult = -a_x1;
      default:        mult = '0;
    endcase
  end

  assign sum     = acc + mult;
  assign acc_nxt = {{2{sum[E+1]}}, sum[E+1:2]};
  assign b_nxt   = {sum[1:0], b_q[E-1:2]};
  assign res     = PW'({acc_nxt[E-1:0], b_nxt});
  assign last    = (cnt == CW'(1));

  assign a_ld = tc ? {{(E-N){a[N-1]}}, a} : {{(E-N){1'b0}}, a};
  assign b_ld = tc ? {{(E-N){b[N-1]}}, b} : {{(E-N){1'b0}}, b};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == CALC);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_q     <= '0;
      b_q     <= '0;
      hist    <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a_ld;
            b_q  <= b_ld;
            hist <= 1'b0;
            acc  <= '0;
            cnt  <= CW'(STEPS);
          end
        end
        CALC: begin
          if (!abort) begin
            acc  <= acc_nxt;
            b_q  <= b_nxt;
            hist <= b_q[1];
            cnt  <= cnt - CW'(1);
            if (last) product <= res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Directed bench for booth_r4_mult at N=8 and N=9 with a product scoreboard.
module tb_booth_r4_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        start8, tc8, abort8, ready8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        start9, tc9, abort9, ready9, busy9, done9;
  logic [8:0]  a9, b9;
  logic [17:0] prod9;

  booth_r4_mult #(.N(8)) u8 (
    .clk(clk), .clr(clr), .start(start8), .tc(tc8), .abort(abort8),
    .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8), .product(prod8)
  );

  booth_r4_mult #(.N(9)) u9 (
    .clk(clk), .clr(clr), .start(start9), .tc(tc9), .abort(abort9),
    .a(a9), .b(b9), .ready(ready9), .busy(busy9), .done(done9), .product(prod9)
  );

  int ncomp = 0;
  int nfail = 0;
  int cyc   = 0;
  int dcnt8 = 0;
  int dcnt9 = 0;
  logic [17:0] sb[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done8 === 1'b1) dcnt8 <= dcnt8 + 1;
    if (done9 === 1'b1) dcnt9 <= dcnt9 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact product by wide integer arithmetic, reduced to 2n bits.
  function automatic logic [17:0] model(input int n, input logic tcv,
                                        input logic [8:0] av, input logic [8:0] bv);
    logic [35:0] mask, ea, eb, p;
    mask = (36'd1 << n) - 36'd1;
    ea = {27'd0, av} & mask;
    eb = {27'd0, bv} & mask;
    if (tcv && av[n-1]) ea = ea | ~mask;
    if (tcv && bv[n-1]) eb = eb | ~mask;
    p = ea * eb;
    mask = (36'd1 << (2 * n)) - 36'd1;
    return 18'(p & mask);
  endfunction

  task automatic launch(input bit is9, input logic tcv, input logic [8:0] av,
                        input logic [8:0] bv, input bit ab, output int st);
    @(negedge clk);
    check("ready_before", 32'(is9 ? ready9 : ready8), 32'd1);
    if (is9) begin
      start9 = 1'b1; tc9 = tcv; a9 = av; b9 = bv; abort9 = ab;
    end else begin
      start8 = 1'b1; tc8 = tcv; a8 = av[7:0]; b8 = bv[7:0]; abort8 = ab;
    end
    st = cyc + 1;
    @(negedge clk);
    start8 = 1'b0; start9 = 1'b0; abort8 = 1'b0; abort9 = 1'b0;
  endtask

  task automatic collect(input bit is9, input int st);
    int g;
    logic [17:0] exp;
    g = 0;
    while (!(is9 ? done9 : done8) && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("done_seen", 32'(is9 ? done9 : done8), 32'd1);
    check("latency", 32'(cyc - st), 32'd5);
    check("sb_depth", 32'(sb.size()), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 18'h3FFFF;
    check("product", 32'(is9 ? prod9 : {2'b00, prod8}), 32'(exp));
    @(negedge clk);
    check("ready_after", 32'(is9 ? ready9 : ready8), 32'd1);
    check("done_low_after", 32'(is9 ? done9 : done8), 32'd0);
  endtask

  task automatic go(input bit is9, input logic tcv, input logic [8:0] av,
                    input logic [8:0] bv, input bit ab);
    int st;
    sb.push_back(model(is9 ? 9 : 8, tcv, av, bv));
    launch(is9, tcv, av, bv, ab, st);
    collect(is9, st);
  endtask

  initial begin
    int st;
    int d0;
    clr = 1'b1;
    start8 = 0; tc8 = 0; abort8 = 0; a8 = 0; b8 = 0;
    start9 = 0; tc9 = 0; abort9 = 0; a9 = 0; b9 = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready8), 32'd1);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_prod8", 32'(prod8), 32'd0);
    check("rst_prod9", 32'(prod9), 32'd0);
    clr = 1'b0;

    // -3 x 5, then the extreme operands in both modes.
    go(1'b0, 1'b1, 9'h0FD, 9'h005, 1'b0);
    check("t1_const", 32'(prod8), 32'hFFF1);
    go(1'b0, 1'b1, 9'h080, 9'h080, 1'b0);
    check("t2_negneg", 32'(prod8), 32'h4000);
    go(1'b0, 1'b0, 9'h0FF, 9'h0FF, 1'b0);
    check("t2_ones", 32'(prod8), 32'hFE01);

    // Second start during CALC plus operand changes must be ignored.
    d0 = dcnt8;
    sb.push_back(model(8, 1'b0, 9'd7, 9'd9));
    launch(1'b0, 1'b0, 9'd7, 9'd9, 1'b0, st);
    a8 = 8'd3; b8 = 8'd3; tc8 = 1'b1;
    check("t3_busy", 32'(busy8), 32'd1);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
    @(negedge clk);
    start8 = 1'b0;
    collect(1'b0, st);
    check("t3_const", 32'(prod8), 32'h003F);
    repeat (8) @(negedge clk);
    check("t3_single_done", 32'(dcnt8 - d0), 32'd1);

    // Abort on the third CALC cycle.
    d0 = dcnt8;
    launch(1'b0, 1'b0, 9'd10, 9'd10, 1'b0, st);
    @(negedge clk);
    @(negedge clk);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    check("t4_ready", 32'(ready8), 32'd1);
    check("t4_busy", 32'(busy8), 32'd0);
    check("t4_hold", 32'(prod8), 32'h003F);
    repeat (6) @(negedge clk);
    check("t4_no_done", 32'(dcnt8 - d0), 32'd0);
    go(1'b0, 1'b0, 9'd10, 9'd10, 1'b1);
    check("t4_const", 32'(prod8), 32'h0064);

    // Asynchronous clear in the middle of CALC.
    d0 = dcnt8;
    launch(1'b0, 1'b1, 9'h085, 9'h033, 1'b0, st);
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check("t5_ready", 32'(ready8), 32'd1);
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_done", 32'(done8), 32'd0);
    check("t5_prod", 32'(prod8), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_no_done", 32'(dcnt8 - d0), 32'd0);

    // N=9: odd width still takes 5 steps.
    go(1'b1, 1'b1, 9'h100, 9'h0FF, 1'b0);
    check("t6_signed", 32'(prod9), 32'h30100);
    go(1'b1, 1'b0, 9'h100, 9'h0FF, 1'b0);
    check("t6_unsigned", 32'(prod9), 32'h0FF00);
    go(1'b1, 1'b1, 9'h100, 9'h100, 1'b0);
    check("t6_negneg", 32'(prod9), 32'h10000);
    go(1'b1, 1'b0, 9'h1FF, 9'h1FF, 1'b0);
    check("t6_ones", 32'(prod9), 32'h3FC01);
    go(1'b0, 1'b1, 9'h000, 9'h05A, 1'b0);
    check("zero", 32'(prod8), 32'd0);

    for (int i = 0; i < 12; i++) begin
      go(1'(i % 2), 1'($urandom % 2), 9'($urandom), 9'($urandom), 1'b0);
    end
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/booth_r4_mult.md
Name: booth_r4_mult

Overview:
- Parametrised sequential radix-4 (modified) Booth multiplier.
- Successor to the radix-2 Booth datapath/controlpath pair. Handles two operand bits per cycle and supports signed or unsigned operands, selected per operation.
- Datapath and FSM live in one module, with a start/done handshake, a synchronous abort, and a product register that holds its value between operations.
- Used wherever a low-area multi-cycle N x N multiply is needed.

Parameters:
- N, 8, operand width in bits (N >= 2).
- E, derived (not overridable): smallest even number >= N+1. This is the internal sign-extended operand width.
- STEPS, derived: E/2. This is the number of Booth iterations.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset.
- start  input  1  request a multiply. Sampled only when ready=1.
- tc  input  1  operand mode, captured with start. 1 = two's complement; 0 = unsigned.
- abort  input  1  synchronous cancel. Effective only in CALC.
- a  input  N  multiplicand, captured on the accepted start edge.
- b  input  N  multiplier, captured on the accepted start edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in CALC only.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2N  result register. Holds its value until the next completed operation.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, ready=1, busy=0, done=0, product=0, all internal registers=0. Asserting clr mid-CALC discards the operation and produces no done.
- FSM has three states: IDLE, CALC, DONE.
- IDLE -> CALC on an edge with start=1. On that edge:
  - latch A = a extended to E bits: sign-extended if tc=1, zero-extended if tc=0.
  - latch B the same way from b.
  - clear the accumulator; set the Booth history bit b[-1]=0; load the step counter with STEPS.
- CALC: one radix-4 step per edge.
  - Recode triple {B[1],B[0],b[-1]}: 000 or 111 -> 0; 001 or 010 -> +A; 011 -> +2A; 100 -> -2A; 101 or 110 -> -A.
  - Add the selected multiple to the upper accumulator. The upper accumulator is E+2 bits wide so that +/-2A cannot overflow.
  - Then arithmetic-shift the combined {acc, B, b[-1]} right by 2 and decrement the counter.
- CALC -> DONE on the edge that performs the final step (counter 1 -> 0). On the same edge:
  - product <= low 2N bits of the 2E-bit result;
  - done goes high.
- DONE -> IDLE on the next edge unconditionally. done is high for exactly one cycle.
- Latency: done is high in the cycle beginning STEPS edges after the start edge. It is independent of tc and of operand values (N=8: 5 cycles; N=9: 5 cycles).
- Throughput: a new start may be accepted on the edge after DONE, i.e. one operation per STEPS+2 cycles.
- start while ready=0 (CALC or DONE) is ignored, with no queuing.
- a, b and tc changes after acceptance have no effect on the running operation.
- abort=1 in CALC returns the FSM to IDLE on that edge. product keeps its previous value and no done is produced.
- abort in IDLE or DONE is ignored. If start=1 and abort=1 arrive together in IDLE, start is accepted.
- Result correctness:
  - tc=1: product equals the exact signed N x N product as a 2N-bit two's-complement value.
  - tc=0: product equals the exact unsigned product in 2N bits.
  - No overflow is possible in either mode.
- Edge operands: most-negative x most-negative and all-ones unsigned must be exact; operand zero gives zero.
- Outputs are registered or decoded from the state register only, with no combinational path from inputs to outputs.

Test Plan:
1. N=8, tc=1, a=-3 (0xFD), b=5, start pulse -> done high exactly 5 cycles after the start edge, product=0xFFF1 (-15), ready returns the cycle after done.
2. N=8, tc=1, a=b=0x80 (-128) -> product=0x4000. Then tc=0, a=b=0xFF -> product=0xFE01 (65025). Same 5-cycle latency in both modes.
3. N=8, start accepted with a=7, b=9. Assert start again with a=2, b=2 during CALC and change a/b -> single done, product=0x003F. The second request is ignored.
4. N=8, after a completed op leaves product=0x003F, start a=10, b=10, then abort on the 3rd CALC cycle -> FSM in IDLE the next cycle, no done pulse, product stays 0x003F. A following start a=10, b=10 yields product=0x0064.
5. clr asserted asynchronously (between clock edges) mid-CALC -> ready=1, busy=0, done=0, product=0 immediately, before the next edge. No done ever appears for the killed operation.
6. N=9, tc=1, a=0x100 (-256), b=0x0FF (255) -> product=0x30100 (-65280 in 18 bits), done 5 cycles after start. With tc=0, same inputs (256 x 255) -> product=0x0FF00.
